// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM profile sequencer: FSM states, table entry layout,
// and the period value that marks the end of the table.
package pwm_seq_pkg;

  localparam int unsigned SEQ_RPW = 8;
  localparam logic [15:0] MARKER_PERIOD = 16'd0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  typedef struct packed {
    logic [15:0]        period;
    logic [7:0]         prescale;
    logic               upnotdown;
    logic [SEQ_RPW-1:0] rpt;
  } seq_entry_t;

endpackage

// File: rtl/pwm_seq_table.sv
// Profile table: DEPTH entries, one write port, two asynchronous read ports
// (full entry at the load index, period only at the look-ahead index).
module pwm_seq_table
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  seq_entry_t    wdata,
  input  logic [AW-1:0] raddr_a,
  output seq_entry_t    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [15:0]   rperiod_b
);

  seq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = mem[raddr_a];
  assign rperiod_b = mem[raddr_b].period;

endmodule

// File: rtl/pwm_sequencer.sv
// Plays back the profile table into the PWM counter: LOAD applies an entry
// with a one-cycle counter_reset, RUN counts full counter cycles via wraps.
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RPW = SEQ_RPW,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [15:0]    cfg_period,
  input  logic [7:0]     cfg_prescale,
  input  logic           cfg_upnotdown,
  input  logic [RPW-1:0] cfg_repeat,
  input  logic           start,
  input  logic           stop,
  input  logic           loop_en,
  input  logic [15:0]    counter_val,
  output logic [15:0]    period,
  output logic [7:0]     prescale,
  output logic           upnotdown,
  output logic           counter_en,
  output logic           counter_reset,
  output logic           busy,
  output logic [AW-1:0]  entry_idx,
  output logic           done
);

  state_t         state, state_n;
  logic [AW-1:0]  idx_n, idx_inc, load_idx;
  logic [RPW-1:0] rpt_cnt;
  logic [15:0]    prev;
  logic [15:0]    next_period;
  logic           prev_ok, armed;
  logic           last_idx, eot, wrap, counted, arm_now, done_n;
  seq_entry_t     wr_entry, load_entry;

  assign wr_entry = '{period:    cfg_period,
                      prescale:  cfg_prescale,
                      upnotdown: cfg_upnotdown,
                      rpt:       SEQ_RPW'(cfg_repeat)};

  assign idx_inc  = entry_idx + AW'(1);
  assign last_idx = (entry_idx == AW'(DEPTH - 1));
  assign eot      = last_idx || (next_period == MARKER_PERIOD);
  // Only a RUN continuing to the next entry loads idx+1; start and loop-back load entry 0.
  assign load_idx = (state == RUN && !eot) ? idx_inc : '0;

  pwm_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk       (clk),
    .rst       (rst),
    .we        (cfg_we),
    .waddr     (cfg_addr),
    .wdata     (wr_entry),
    .raddr_a   (load_idx),
    .rdata_a   (load_entry),
    .raddr_b   (idx_inc),
    .rperiod_b (next_period)
  );

  // prev is only trusted once it was captured in RUN; the value seen during
  // LOAD may be a stray tick from the previous entry and could fake a wrap.
  assign wrap = prev_ok && (upnotdown ? (prev == period && counter_val == '0)
                                      : (prev == '0 && counter_val == period));
  assign counted = wrap && (upnotdown || armed);
  assign arm_now = wrap && !upnotdown && !armed;

  always_comb begin
    state_n = state;
    idx_n   = entry_idx;
    done_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx_n = '0;
            if (load_entry.period == MARKER_PERIOD) done_n = 1'b1;
            else state_n = LOAD;
          end
        end
        LOAD: state_n = RUN;
        RUN: begin
          if (counted && rpt_cnt == '0) begin
            if (eot && !loop_en) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = LOAD;
              idx_n   = load_idx;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      entry_idx     <= '0;
      period        <= '0;
      prescale      <= '0;
      upnotdown     <= 1'b1;
      rpt_cnt       <= '0;
      armed         <= 1'b0;
      prev          <= '0;
      prev_ok       <= 1'b0;
      counter_en    <= 1'b0;
      counter_reset <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      entry_idx     <= idx_n;
      done          <= done_n;
      counter_reset <= (state_n == LOAD);
      counter_en    <= (state_n == RUN);
      busy          <= (state_n != IDLE);
      prev          <= counter_val;
      prev_ok       <= (state == RUN);
      if (state_n == LOAD) begin
        period    <= load_entry.period;
        prescale  <= load_entry.prescale;
        upnotdown <= load_entry.upnotdown;
        rpt_cnt   <= RPW'(load_entry.rpt);
        armed     <= 1'b0;
      end else if (state == RUN) begin
        if (arm_now) armed <= 1'b1;
        if (counted && rpt_cnt != '0) rpt_cnt <= rpt_cnt - RPW'(1);
      end
    end
  end

endmodule

// File: doc/pwm_sequencer.md
# pwm_sequencer

Profile sequencer for the PWM counter. Holds a small table of counter configurations (period, prescale, direction, repeat count) and plays them back in order. Each entry is applied through a one-cycle `counter_reset`, runs for a programmed number of full counter cycles detected from `counter_val`, then the next entry is applied. Sits between the register block (table writes, start/stop) and the `counter` inputs.

## Interface
- `DEPTH`, 4: number of table entries (power of two, ≥2)
- `RPW`, 8: repeat-count width
- `clk` input 1: system clock
- `rst` input 1: reset; synchronous to `clk`, active-high
- `cfg_we` input 1: table write strobe
- `cfg_addr` input $clog2(DEPTH): table write index
- `cfg_period` input 16: entry period; 0 = end-of-table marker
- `cfg_prescale` input 8: entry prescale (2^N)
- `cfg_upnotdown` input 1: entry direction, 1 = up
- `cfg_repeat` input RPW: entry runs `cfg_repeat+1` full cycles
- `start` input 1: begin playback at entry 0
- `stop` input 1: abort playback
- `loop_en` input 1: after the last entry, restart at entry 0 instead of finishing
- `counter_val` input 16: current `counter` value
- `period` output 16: to `counter`
- `prescale` output 8: to `counter`
- `upnotdown` output 1: to `counter`
- `counter_en` output 1: to `counter`
- `counter_reset` output 1: to `counter`
- `busy` output 1: high in LOAD/RUN
- `entry_idx` output $clog2(DEPTH): entry currently applied
- `done` output 1: one-cycle pulse at normal completion

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: `counter_en`=0 and `counter_reset`=0. `start` → check entry 0. If entry 0 has period 0, pulse `done` and stay in IDLE. Otherwise go to LOAD with idx=0.
- LOAD (exactly 1 cycle): latch entry[idx] into `period`/`prescale`/`upnotdown` and the repeat counter. Drive `counter_reset`=1 and `counter_en`=0. Clear `armed`. Go to RUN.
- RUN: `counter_en`=1. Keep `prev` = `counter_val` from the previous cycle.
  - Wrap, up mode: `prev`==`period` and `counter_val`==0.
  - Wrap, down mode: `prev`==0 and `counter_val`==`period`.
  - Down mode only: the first 0→period reload after LOAD is not counted; it sets `armed`. Down-mode wraps count only once `armed` is set. Up mode is always armed.
- On a counted wrap with repeat counter ≠0: decrement it and stay in RUN.
- On a counted wrap with repeat counter =0: next = idx+1.
  - If next == DEPTH, or entry[next] period == 0: end of table. With `loop_en`=1 (sampled that cycle) go to LOAD with idx=0. Otherwise pulse `done` and go to IDLE.
  - Otherwise go to LOAD with idx=next.
- `stop` in any state → IDLE next cycle: `counter_en`=0, no `done`. The `period`/`prescale`/`upnotdown` outputs hold their values.
- `stop` and `start` in the same cycle: `stop` wins.
- `start` while busy: ignored.
- Table writes are allowed at any time. An entry is read only at LOAD (and at the end-of-table check), so rewriting the running entry does not affect the current run.
- Reset values:
  - All table fields 0, so every entry is a marker.
  - `period`=0, `prescale`=0, `upnotdown`=1.
  - `counter_en`=0, `counter_reset`=0, `busy`=0, `done`=0, `entry_idx`=0.
  - State IDLE, `armed`=0.
  - `rst` mid-playback returns all of the above on the next edge.

## Timing
- `start` sampled at edge T → LOAD during cycle T+1 (`counter_reset`=1, new config valid) → RUN from T+2 (`counter_en`=1).
- Wrap detection is combinational on `counter_val` vs registered `prev`. A final wrap seen in cycle W gives LOAD (or IDLE with `done`=1) in W+1.
- One extra counter tick may occur in cycle W. It is cleared by the `counter_reset` in W+1.
- All outputs are registered.
- Entry-to-entry gap: exactly 1 cycle with `counter_en`=0.

## Structure
- `pwm_seq_pkg`:
  - `state_t` enum {IDLE, LOAD, RUN}
  - `seq_entry_t` struct {period[15:0], prescale[7:0], upnotdown, repeat[RPW-1:0]}
  - localparam `MARKER_PERIOD`=0
- Sub-module `pwm_seq_table`: DEPTH×`seq_entry_t` register file with one write port and two asynchronous read ports (current idx and idx+1). Synchronous reset clears it to zero.

## Test plan
- Entry0 {P=3, PS=0, up, R=1}, entry1 marker, `start` → `counter_reset` one cycle later, then 8 counter cycles of RUN (0..3 twice), then `done` pulse, `busy`=0.
- Entry0 {P=2, down, R=0}, entry1 {P=5, up, R=0}, `start` → the first 0→2 reload is ignored. The next 0→2 wrap triggers LOAD; `entry_idx`=1, `period`=5, `upnotdown`=1. Completion follows after 6 counted values.
- All 4 entries valid, `loop_en`=1 → after entry3's final wrap, `entry_idx`=0 and LOAD occurs; no `done`. Clearing `loop_en` before the next end → `done` pulse.
- `stop` asserted mid-RUN together with `start` → IDLE next cycle, `counter_en`=0, no `done`. A `start` alone afterwards restarts at entry 0.
- `start` with entry0 period=0 → `done` pulse next cycle, `counter_reset` never asserted.
- Rewrite entry0 period 3→7 during its run with R=2 → all three runs use 3. After a loop back, the new value 7 appears at LOAD. `rst` mid-RUN → all outputs at reset values next cycle.
